nebula_credit_rx_buffer: RTL



---
 rtl/nebula_credit_rx_buffer.sv | 85 ++++++++
 1 files changed

// File: rtl/nebula_credit_rx_buffer.sv
// Receiver end of a credit-based NoC link: a BUF_DEPTH-entry first-word-fall-through FIFO
// that returns one registered credit pulse upstream for every flit the consumer drains.
module nebula_credit_rx_buffer #(
   parameter int BUF_DEPTH  = 4,
   parameter int FLIT_WIDTH = 64,
   parameter int CNT_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [FLIT_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [FLIT_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic                  credit_return,
   output logic [CNT_WIDTH-1:0]  occupancy,
   output logic                  overflow_err
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(BUF_DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(BUF_DEPTH);

   logic [FLIT_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  full;
   logic                  push;
   logic                  drop;
   logic                  pop;

   // Fullness uses the pre-pop count: a slot freed this cycle has not yet been credited upstream.
   assign full      = (occupancy == FULL_CNT);
   assign push      = in_valid & ~full;
   assign drop      = in_valid & full;
   assign out_valid = (occupancy != '0);
   assign pop       = out_valid & out_ready;
   assign out_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         occupancy     <= '0;
         credit_return <= 1'b0;
         overflow_err  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            occupancy <= occupancy + CNT_WIDTH'(1);
         end else if (pop && !push) begin
            occupancy <= occupancy - CNT_WIDTH'(1);
         end
         credit_return <= pop;
         if (drop) begin
            overflow_err <= 1'b1;
         end
      end
   end

`ifdef ASSERT_ON
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (occupancy <= FULL_CNT)
            else $error("occupancy exceeds BUF_DEPTH");
         assert (!drop)
            else $error("flit arrived while buffer full");
         assert (!(out_valid && $isunknown(out_data)))
            else $error("out_data unknown while out_valid");
      end
   end
`endif

endmodule
